// File: rtl/rtc_calendar.sv
// BCD day/month/year calendar register. Advances one day per new_day_i strobe,
// handling month lengths, Gregorian leap years and the 3999 -> 0000 year wrap.
module rtc_calendar #(
    parameter logic [31:0] RESET_DATE = 32'h2000_0101
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        date_update_i,
    input  logic [31:0] date_i,
    input  logic        new_day_i,
    output logic [31:0] date_o,
    output logic        new_month_o,
    output logic        new_year_o
);

    logic [5:0]  day_q,   day_nxt;
    logic [4:0]  month_q, month_nxt;
    logic [13:0] year_q,  year_nxt;
    logic [5:0]  last_day;
    logic        leap, roll_month, roll_year;
    logic        new_month_q, new_year_q;
    logic        unused_rsvd;

    assign unused_rsvd = ^{date_i[31:30], date_i[15:13], date_i[7:6]};

    // Two-digit BCD value divisible by 4: only the parity of the tens digit matters.
    function automatic logic div4(input logic [7:0] v);
        return (!v[4] && (v[3:0] == 4'd0 || v[3:0] == 4'd4 || v[3:0] == 4'd8)) ||
               ( v[4] && (v[3:0] == 4'd2 || v[3:0] == 4'd6));
    endfunction

    function automatic logic [13:0] year_inc(input logic [13:0] y);
        logic [13:0] r;
        r = y;
        if (y[3:0] < 4'd9) r[3:0] = y[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (y[7:4] < 4'd9) r[7:4] = y[7:4] + 4'd1;
            else begin
                r[7:4] = 4'd0;
                if (y[11:8] < 4'd9) r[11:8] = y[11:8] + 4'd1;
                else begin
                    r[11:8]  = 4'd0;
                    r[13:12] = y[13:12] + 2'd1;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        leap = (year_q[7:0] != 8'h00 && div4(year_q[7:0])) ||
               (year_q[7:0] == 8'h00 && div4({2'b00, year_q[13:8]}));

        // Unknown month codes get 31 days so any written day still rolls over.
        case (month_q)
            5'h04, 5'h06, 5'h09, 5'h11: last_day = 6'h30;
            5'h02:                      last_day = leap ? 6'h29 : 6'h28;
            default:                    last_day = 6'h31;
        endcase

        roll_month = (day_q >= last_day);
        roll_year  = roll_month && (month_q >= 5'h12);

        if (roll_month)           day_nxt = 6'h01;
        else if (day_q[3:0] >= 4'd9) day_nxt = {day_q[5:4] + 2'd1, 4'd0};
        else                      day_nxt = {day_q[5:4], day_q[3:0] + 4'd1};

        if (!roll_month)            month_nxt = month_q;
        else if (roll_year)         month_nxt = 5'h01;
        else if (month_q[3:0] >= 4'd9) month_nxt = {~month_q[4], 4'd0};
        else                        month_nxt = {month_q[4], month_q[3:0] + 4'd1};

        year_nxt = roll_year ? year_inc(year_q) : year_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            day_q       <= RESET_DATE[5:0];
            month_q     <= RESET_DATE[12:8];
            year_q      <= RESET_DATE[29:16];
            new_month_q <= 1'b0;
            new_year_q  <= 1'b0;
        end else begin
            new_month_q <= 1'b0;
            new_year_q  <= 1'b0;
            if (date_update_i) begin
                day_q   <= date_i[5:0];
                month_q <= date_i[12:8];
                year_q  <= date_i[29:16];
            end else if (new_day_i) begin
                day_q       <= day_nxt;
                month_q     <= month_nxt;
                year_q      <= year_nxt;
                new_month_q <= roll_month;
                new_year_q  <= roll_year;
            end
        end
    end

    assign date_o      = {2'b00, year_q, 3'b000, month_q, 2'b00, day_q};
    assign new_month_o = new_month_q;
    assign new_year_o  = new_year_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed bench for rtc_calendar: an integer date model is compared against the
// DUT every cycle, plus literal expectations for the documented corner dates.
module tb_rtc_calendar;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        date_update_i;
    logic [31:0] date_i;
    logic        new_day_i;
    logic [31:0] date_o;
    logic        new_month_o;
    logic        new_year_o;

    rtc_calendar dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .date_update_i (date_update_i),
        .date_i        (date_i),
        .new_day_i     (new_day_i),
        .date_o        (date_o),
        .new_month_o   (new_month_o),
        .new_year_o    (new_year_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int my, mm, md;
    bit mnm, mny;

    function automatic logic [31:0] pack(input int y, input int m, input int d);
        logic [13:0] yb;
        logic [4:0]  mb;
        logic [5:0]  db;
        yb = {2'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
        mb = {1'(m / 10), 4'(m % 10)};
        db = {2'(d / 10), 4'(d % 10)};
        return {2'b00, yb, 3'b000, mb, 2'b00, db};
    endfunction

    function automatic bit is_leap(input int y);
        return (y % 4 == 0 && y % 100 != 0) || (y % 400 == 0);
    endfunction

    function automatic int days_in(input int y, input int m);
        case (m)
            4, 6, 9, 11: return 30;
            2:           return is_leap(y) ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        my = 2000; mm = 1; md = 1; mnm = 0; mny = 0;
    endtask

    task automatic model_step(input bit upd, input logic [31:0] din, input bit nd);
        mnm = 0; mny = 0;
        if (upd) begin
            my = int'(din[29:28]) * 1000 + int'(din[27:24]) * 100 + int'(din[23:20]) * 10 + int'(din[19:16]);
            mm = int'(din[12]) * 10 + int'(din[11:8]);
            md = int'(din[5:4]) * 10 + int'(din[3:0]);
        end else if (nd) begin
            if (md >= days_in(my, mm)) begin
                md = 1; mnm = 1;
                if (mm >= 12) begin
                    mm = 1; mny = 1; my = (my + 1) % 4000;
                end else mm = mm + 1;
            end else md = md + 1;
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge settles.
    task automatic cycle(input bit upd, input logic [31:0] din, input bit nd);
        date_update_i = upd; date_i = din; new_day_i = nd;
        model_step(upd, din, nd);
        @(posedge clk_i);
        @(negedge clk_i);
        check("model_date", date_o, pack(my, mm, md));
        check("model_new_month", {31'b0, new_month_o}, {31'b0, mnm});
        check("model_new_year",  {31'b0, new_year_o},  {31'b0, mny});
    endtask

    task automatic load(input logic [31:0] d); cycle(1'b1, d, 1'b0); endtask
    task automatic nday(); cycle(1'b0, 32'h0, 1'b1); endtask
    task automatic idle(); cycle(1'b0, 32'h0, 1'b0); endtask

    initial begin
        rstn_i = 1'b0; date_update_i = 1'b0; date_i = 32'h0; new_day_i = 1'b0;
        model_reset();
        #12;
        @(negedge clk_i);
        check("reset_date", date_o, 32'h2000_0101);
        check("reset_new_month", {31'b0, new_month_o}, 32'h0);
        check("reset_new_year",  {31'b0, new_year_o},  32'h0);
        rstn_i = 1'b1;
        idle();

        load(32'h2023_0228); check("load_0228", date_o, 32'h2023_0228);
        nday(); check("feb_to_mar", date_o, 32'h2023_0301);
        check("feb_to_mar_pulse", {31'b0, new_month_o}, 32'h1);
        idle(); check("pulse_once", {31'b0, new_month_o}, 32'h0);
        load(32'h2023_0109); nday(); check("day_units_carry", date_o, 32'h2023_0110);
        load(32'h2023_1019); nday(); check("day_tens_carry", date_o, 32'h2023_1020);
        load(32'h2023_0630); nday(); check("june_30", date_o, 32'h2023_0701);
        load(32'h2023_0930); nday(); check("sep_to_oct", date_o, 32'h2023_1001);

        load(32'h2024_0228); nday(); check("leap_2024_29", date_o, 32'h2024_0229);
        nday(); check("leap_2024_mar", date_o, 32'h2024_0301);
        load(32'h2000_0228); nday(); check("leap_2000", date_o, 32'h2000_0229);
        load(32'h2100_0228); nday(); check("noleap_2100", date_o, 32'h2100_0301);

        load(32'h1999_1231); nday(); check("y2k", date_o, 32'h2000_0101);
        check("y2k_new_month", {31'b0, new_month_o}, 32'h1);
        check("y2k_new_year",  {31'b0, new_year_o},  32'h1);
        load(32'h3999_1231); nday(); check("wrap_3999", date_o, 32'h0000_0101);

        cycle(1'b1, 32'h2024_0430, 1'b1); check("update_wins", date_o, 32'h2024_0430);
        nday(); check("after_update", date_o, 32'h2024_0501);

        load(32'h2023_1229);
        repeat (4) nday();
        check("held_new_day", date_o, 32'h2024_0102);

        load(32'hE021_E5D5); check("reserved_ignored", date_o, 32'h2021_0515);

        load(32'h2025_0435); nday(); check("day_overrange", date_o, 32'h2025_0501);

        // Async reset while a strobe is pending must take effect before any edge.
        new_day_i = 1'b1; rstn_i = 1'b0;
        model_reset();
        #2;
        check("async_reset_date", date_o, 32'h2000_0101);
        check("async_reset_pulse", {31'b0, new_month_o}, 32'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("reset_held", date_o, 32'h2000_0101);
        new_day_i = 1'b0; rstn_i = 1'b1;
        idle();
        nday(); check("post_reset_day", date_o, 32'h2000_0102);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
